// File: rtl/dpd_feature_extract.sv
// dpd_feature_extract: per-sample |x| and |x|^3 extraction with a TAPS-deep
// memory delay line, producing the flattened feature vector that feeds both
// the first backbone layer and the dense path into the output layer.
// One sample is processed at a time: IDLE -> MAG -> SQRT (DATA_W cycles) ->
// CUBE -> OUT.
module dpd_feature_extract #(
   parameter int DATA_W = 14,
   parameter int TAPS   = 3,
   parameter int FEATS  = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [DATA_W-1:0]          in_i,
   input  logic signed [DATA_W-1:0]          in_q,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [TAPS*FEATS*DATA_W-1:0]      out_feat
);

   localparam int TAP_W  = FEATS * DATA_W;
   localparam int VEC_W  = TAPS * TAP_W;
   localparam int MAG_W  = 2 * DATA_W;          // |x|^2, frac 2*(DATA_W-1)
   localparam int REM_W  = DATA_W + 4;          // holds 4*rem+3 with rem <= 2*root
   localparam int PROD_W = 3 * DATA_W;          // root * mag2
   localparam int CNT_W  = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] SQRT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (DATA_W - 1)) - 1);

   typedef enum logic [2:0] {
      IDLE,
      MAG,
      SQRT,
      CUBE,
      OUT
   } state_t;

   state_t state_q, state_d;

   logic signed [DATA_W-1:0] i_p0, q_p0;
   logic [MAG_W-1:0]         mag2_p1;
   logic [MAG_W-1:0]         rad_p1;
   logic [REM_W-1:0]         rem_p1;
   logic [DATA_W-1:0]        root_p1;
   logic [CNT_W-1:0]         cnt_p1;

   // Clamp a non-negative magnitude to the largest positive Q1.(DATA_W-1) code.
   function automatic logic signed [DATA_W-1:0] sat_u(input logic [PROD_W-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[DATA_W-1:0];
      end
      return v[DATA_W-1:0];
   endfunction

   // |x|^2 from the latched sample; (-full scale)^2 fits the signed square,
   // and the sum of two squares (max 2^(MAG_W-1)) fits MAG_W unsigned bits.
   logic signed [MAG_W-1:0] i_ext, q_ext, i_sq, q_sq;
   logic [MAG_W-1:0]        mag2_d;
   always_comb begin
      i_ext  = {{DATA_W{i_p0[DATA_W-1]}}, i_p0};
      q_ext  = {{DATA_W{q_p0[DATA_W-1]}}, q_p0};
      i_sq   = i_ext * i_ext;
      q_sq   = q_ext * q_ext;
      mag2_d = $unsigned(i_sq) + $unsigned(q_sq);
   end

   // One digit-by-digit square-root step: bring down two radicand bits and
   // try to subtract (4*root + 1).
   logic [REM_W-1:0]  rem_sh, trial, rem_d;
   logic [DATA_W-1:0] root_d;
   logic              take;
   always_comb begin
      rem_sh = (rem_p1 << 2) | REM_W'(rad_p1[MAG_W-1 -: 2]);
      trial  = (REM_W'(root_p1) << 2) | REM_W'(1);
      take   = (rem_sh >= trial);
      rem_d  = take ? (rem_sh - trial) : rem_sh;
      root_d = (root_p1 << 1) | DATA_W'(take);
   end

   // |x|^3 = root * mag2 with the extra fractional bits truncated, then the
   // new tap assembled in element order I, Q, |x|, |x|^3.
   logic [PROD_W-1:0]        prod, cube_sh;
   logic signed [DATA_W-1:0] mag_sat, cube_sat;
   logic [TAP_W-1:0]         new_tap;
   always_comb begin
      prod     = PROD_W'(root_p1) * PROD_W'(mag2_p1);
      cube_sh  = prod >> (MAG_W - 2);
      mag_sat  = sat_u(PROD_W'(root_p1));
      cube_sat = sat_u(cube_sh);
      new_tap  = {cube_sat, mag_sat, q_p0, i_p0};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; nothing here looks at out_ready
   // except the OUT exit, so in_ready never depends on it combinationally.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = MAG;
         end
         MAG:  state_d = SQRT;
         SQRT: if (cnt_p1 == '0) state_d = CUBE;
         CUBE: state_d = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sample latch, square-root iteration and delay line; reset clears the
   // taps so warm-up vectors carry zeros for unfilled older taps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_p0     <= '0;
         q_p0     <= '0;
         mag2_p1  <= '0;
         rad_p1   <= '0;
         rem_p1   <= '0;
         root_p1  <= '0;
         cnt_p1   <= '0;
         out_feat <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  i_p0 <= in_i;
                  q_p0 <= in_q;
               end
            end
            MAG: begin
               mag2_p1 <= mag2_d;
               rad_p1  <= mag2_d;
               rem_p1  <= '0;
               root_p1 <= '0;
               cnt_p1  <= SQRT_LAST;
            end
            SQRT: begin
               rad_p1  <= rad_p1 << 2;
               rem_p1  <= rem_d;
               root_p1 <= root_d;
               if (cnt_p1 != '0) cnt_p1 <= cnt_p1 - 1'b1;
            end
            CUBE: begin
               out_feat <= {out_feat[VEC_W-TAP_W-1:0], new_tap};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dpd_feature_extract.sv
// Directed bench for dpd_feature_extract with hand-computed feature values.
module tb_dpd_feature_extract;

   localparam int DW = 14;
   localparam int TP = 3;
   localparam int FT = 4;
   localparam int VW = TP * FT * DW;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_i = '0;
   logic signed [DW-1:0] in_q = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [VW-1:0]        out_feat;

   int            total = 0;
   int            bad = 0;
   logic [VW-1:0] exp_vec = '0;

   dpd_feature_extract #(.DATA_W(DW), .TAPS(TP), .FEATS(FT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_i      (in_i),
      .in_q      (in_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_feat  (out_feat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic signed [DW-1:0] feat(input int e);
      return out_feat[e*DW +: DW];
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag);
      total++;
      assert (out_feat === exp_vec) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, out_feat, exp_vec);
      end
   endtask

   task automatic push(input int i, input int q, input int m, input int c);
      exp_vec = {exp_vec[VW-FT*DW-1:0], 14'(c), 14'(m), 14'(q), 14'(i)};
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", in_ready, 1);
   endtask

   task automatic accept(input int i, input int q);
      wait_ready();
      in_i     = 14'(i);
      in_q     = 14'(q);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run(input string tag, input int i, input int q, input int m, input int c);
      int n;
      accept(i, q);
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, 17);
      push(i, q, m, c);
      chk_vec({tag, "_vec"});
      chk({tag, "_busy"}, in_ready, 0);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk_vec("reset_vec");
      rst_n = 1'b1;
      @(negedge clk);

      // single samples: real axis, 3-4-5 triangle, saturating corner
      run("s1", 4096, 0, 4096, 1024);
      @(negedge clk);
      chk("s1_ready_next", in_ready, 1);
      chk("s1_valid_drop", out_valid, 0);
      run("s2", 3072, 4096, 5120, 2000);
      chk("s2_tap1_mag", feat(6), 4096);
      run("s3", -8192, -8192, 8191, 8191);
      chk("s3_i", feat(0), -8192);
      chk("s3_q", feat(1), -8192);
      chk("s3_mag_sat", feat(2), 8191);
      chk("s3_cube_sat", feat(3), 8191);

      // three consecutive samples A, B (zero), C
      run("a", 1000, -2000, 2236, 166);
      run("b", 0, 0, 0, 0);
      run("c", -4096, 4096, 5792, 2896);
      chk("c_tap0_mag", feat(2), 5792);
      chk("c_tap1_mag", feat(6), 0);
      chk("c_tap1_cube", feat(7), 0);
      chk("c_tap2_i", feat(8), 1000);
      chk("c_tap2_q", feat(9), -2000);
      chk("c_tap2_cube", feat(11), 166);

      // stalled OUT for 40 cycles with ignored input pulses
      @(negedge clk);
      out_ready = 1'b0;
      run("d", 2048, 0, 2048, 128);
      for (int k = 0; k < 40; k++) begin
         in_valid = (k % 3 == 0);
         in_i     = 14'(100);
         in_q     = -14'(100);
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 0);
         chk_vec("stall_vec");
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_ready", in_ready, 1);
      chk("release_valid", out_valid, 0);
      run("e", 0, 4096, 4096, 1024);

      // reset in the middle of SQRT
      @(negedge clk);
      accept(4096, 0);
      repeat (7) @(negedge clk);
      chk("midrst_pre_busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      exp_vec = '0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk_vec("midrst_vec");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run("g", 3072, 4096, 5120, 2000);
      chk("g_tap1_i", feat(4), 0);
      chk("g_tap2_mag", feat(10), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpd_feature_extract.md
# dpd_feature_extract

Upstream feature-extraction stage of the sparse DPD network. Takes one complex baseband sample (I, Q) per handshake and computes |x| and |x|^3 per sample. It keeps a 3-tap memory delay line and presents a 12-element feature vector to the first backbone linear layer, which is 12 inputs wide. The same vector also feeds the dense path into the output layer. Iterative square root; one sample in flight at a time.

## Interface
- `DATA_W`, default 14: signed width of I, Q and every feature; Q-format 1.13 (quantizer exponent -13).
- `TAPS`, default 3: memory depth; current sample plus 2 previous.
- `FEATS`, default 4: features per tap (I, Q, |x|, |x|^3); vector length TAPS*FEATS = 12.
- `clk`  in  1: sole clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input sample valid.
- `in_ready`  out  1: block can accept a sample.
- `in_i`, `in_q`  in  DATA_W each: signed sample, Q1.13.
- `out_valid`  out  1: feature vector valid.
- `out_ready`  in  1: consumer accepts vector.
- `out_feat`  out  TAPS*FEATS*DATA_W (168): flattened vector; element e occupies bits [e*DATA_W +: DATA_W].

## Operation
- Element ordering: e = 4k+j. Tap k=0 is the newest sample, k=2 the oldest. j=0 is I, j=1 is Q, j=2 is |x|, j=3 is |x|^3.
- FSM states: IDLE, MAG, SQRT, CUBE, OUT.
- IDLE: in_ready=1. On in_valid, latch in_i/in_q and go to MAG.
- MAG: mag2 = in_i^2 + in_q^2. Unsigned, 28 bits, frac 26, max 2^27. Go to SQRT.
- SQRT: non-restoring/digit-by-digit integer sqrt, one result bit per cycle, 14 cycles, MSB first.
  - Result r = floor(sqrt(mag2)), unsigned 14 bits, frac 13.
  - An iteration counter 13..0 ends the state; go to CUBE.
- CUBE: p = (r * mag2) >> 26, truncation (floor), frac 13.
- Saturation: r and p saturate independently to 8191 (+0.99988). Neither can be negative.
- At CUBE exit, shift the delay line: tap2 <- tap1, tap1 <- tap0, tap0 <- {I, Q, sat(r), sat(p)}. Go to OUT.
- OUT: out_valid=1 and out_feat is stable. On out_ready go to IDLE. Hold indefinitely otherwise.
- in_ready=0 in every state except IDLE. Input ignored when in_ready=0.
- Delay line warm-up: taps reset to zero. The first vectors contain zeros for the not-yet-filled older taps; no suppression.
- No state or delay-line update except as listed. A stalled OUT does not lose or duplicate a sample.

## Timing
- Reset (rst_n low, any time, including mid-SQRT): state=IDLE, in_ready=1 after deassertion, out_valid=0, out_feat=0, all delay taps=0, sqrt accumulators and counter=0. An in-flight sample is discarded.
- Latency: input accepted at edge of cycle t, so out_valid=1 in cycle t+17. That is MAG at t+1, SQRT at t+2..t+15, CUBE at t+16, OUT at t+17.
- Throughput: with out_ready held high, one sample per 18 cycles. in_ready rises in cycle t+18.
- out_feat is registered; changes only on the CUBE->OUT transition and on reset.
- in_valid and in_ready are never combinationally dependent on out_ready.

## Test plan
- Reset, then apply I=4096, Q=0 with out_ready=1. Expect out_valid exactly 17 cycles after acceptance. Tap0 = {4096, 0, 4096, 1024}; taps 1 and 2 all zero.
- I=3072, Q=4096 (3-4-5 triangle). Expect tap0 = {3072, 4096, 5120, 2000} (mag2=26214400).
- I=-8192, Q=-8192. Expect |x| sqrt=11585 saturated to 8191, and |x|^3 (raw 23170) saturated to 8191. I and Q are passed unchanged as -8192.
- Three consecutive samples A, B, C. After C, expect out_feat[0:3]=C, [4:7]=B, [8:11]=A. I=Q=0 yields zero magnitude features.
- Hold out_ready=0 for 40 cycles during OUT:
  - out_valid stays 1, out_feat stays unchanged, in_ready stays 0.
  - in_valid pulses meanwhile are not accepted.
  - After out_ready, in_ready=1 the next cycle.
- Assert rst_n low during SQRT (cycle t+8). Expect immediate out_valid=0 and all taps zero. The next sample produces a vector with only tap0 nonzero.
